// File: rtl/pipe_hazard_ctrl.sv
// ID/EX issue-stall controller: per-register pending-write scoreboard plus multi-cycle MUL sequencer.
// Optional HAZ_STATS_EN adds saturating stall_cnt / mul_stall_cnt counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned REG_NUM     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rena1,
  input  logic               id_rena2,
  input  logic [4:0]         id_rd,
  input  logic               id_wena,
  input  logic               id_is_mul,
  input  logic               flush,
  input  logic               wb_wena,
  input  logic [4:0]         wb_rd,
  output logic               issue,
  output logic               stall,
  output logic               bubble,
  output logic               mul_start,
  output logic               mul_busy,
  output logic               mul_done,
  output logic [REG_NUM-1:0] sb_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        mul_stall_cnt
`endif
);

  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {StIdle, StRun} mul_state_e;

  mul_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [REG_NUM-1:0] sb_q, sb_d;
  logic [REG_NUM-1:0] wb_hit;
  logic [REG_NUM-1:0] eff;
  logic               reg_hazard;
  logic               mul_hazard;
  logic               hazard;

  // Write-first register file: a same-cycle writeback already resolves the pending write.
  always_comb begin
    wb_hit = '0;
    for (int n = 1; n < int'(REG_NUM); n++) begin
      wb_hit[n] = wb_wena && (wb_rd == 5'(n));
    end
    eff = sb_q & ~wb_hit;
  end

  always_comb begin
    mul_busy   = (state_q == StRun);
    mul_done   = mul_busy && (cnt_q == '0);
    reg_hazard = (id_rena1 && (id_rs != 5'd0) && eff[id_rs]) ||
                 (id_rena2 && (id_rt != 5'd0) && eff[id_rt]) ||
                 (id_wena  && (id_rd != 5'd0) && eff[id_rd]);
    mul_hazard = id_is_mul && mul_busy && !mul_done;
    hazard     = reg_hazard || mul_hazard;
    issue      = !rst && id_valid && !flush && !hazard;
    stall      = !rst && id_valid && !flush && hazard;
    bubble     = !issue;
    mul_start  = issue && id_is_mul;
  end

  always_comb begin
    sb_d = sb_q & ~wb_hit;
    if (issue && id_wena && (id_rd != 5'd0)) begin
      sb_d[id_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mul_start) begin
          state_d = StRun;
          cnt_d   = CntW'(MUL_LATENCY - 1);
        end
      end
      StRun: begin
        if (mul_start) begin
          // Back-to-back Mul: reload on the done cycle and stay in RUN.
          cnt_d = CntW'(MUL_LATENCY - 1);
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

  assign sb_busy = sb_q;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] mul_stall_cnt_q, mul_stall_cnt_d;

  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    mul_stall_cnt_d = mul_stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Counted only when MUL occupancy is the sole reason for the stall.
    if (stall && mul_hazard && !reg_hazard && (mul_stall_cnt_q != 32'hFFFF_FFFF)) begin
      mul_stall_cnt_d = mul_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q     <= '0;
      mul_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      mul_stall_cnt_q <= mul_stall_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign mul_stall_cnt = mul_stall_cnt_q;
`endif

endmodule
